// File: rtl/rr_arbiter.sv
// Round-robin packet arbiter: N requesters share one registered output stage.
// Arbitration takes one IDLE cycle; the winner then owns the output until
// its last beat is accepted. The owner cannot lose the grant by going quiet.
module rr_arbiter #(
  parameter int data_bits = 8,
  parameter int sel_bits  = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [2**sel_bits-1:0]                 req_valid,
  input  logic [2**sel_bits-1:0][data_bits-1:0]  req_data,
  input  logic [2**sel_bits-1:0]                 req_last,
  output logic [2**sel_bits-1:0]                 req_ready,
  output logic                                   out_valid,
  output logic [data_bits-1:0]                   out_data,
  output logic                                   out_last,
  input  logic                                   out_ready,
  output logic [sel_bits-1:0]                    grant_sel,
  output logic                                   busy
);

  localparam int n = 2**sel_bits;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state, state_next;
  logic [sel_bits-1:0] ptr, ptr_next, grant_next, pick;
  logic                found;
  logic                slot_free;
  logic                accept;

  // The output register can take a beat when empty or draining this cycle.
  assign slot_free = !out_valid || out_ready;
  assign busy      = (state == LOCKED);

  // Round-robin scan: first valid requester at or after ptr, wrapping modulo n.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write;
    // a path that leaves one unassigned would infer a latch.
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (!found && req_valid[ptr + sel_bits'(k)]) begin
        found = 1'b1;
        pick  = ptr + sel_bits'(k);
      end
    end
  end

  // Next-state, grant/pointer update and per-requester ready.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    grant_next = grant_sel;
    req_ready  = '0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_next = LOCKED;
          grant_next = pick;
        end
      end
      LOCKED: begin
        // Ready is suppressed during reset so an in-flight beat is dropped.
        req_ready[grant_sel] = slot_free && !rst;
        accept               = req_valid[grant_sel] && slot_free && !rst;
        if (accept && req_last[grant_sel]) begin
          state_next = IDLE;
          ptr_next   = grant_sel + sel_bits'(1);
        end
      end
    endcase
  end

  // State, round-robin pointer and current owner.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_sel <= '0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      grant_sel <= grant_next;
    end
  end

  // Output stage: load on accept, hold while stalled, empty after transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= req_data[grant_sel];
      out_last  <= req_last[grant_sel];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (sel_bits=2, data_bits=8). Expected output
// beats are queued as stimulus is issued; a negedge monitor pops and compares
// on every output transfer. Control outputs are checked directly mid-cycle.
module tb_rr_arbiter;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req_valid;
  logic [3:0][7:0] req_data;
  logic [3:0]      req_last;
  logic [3:0]      req_ready;
  logic            out_valid;
  logic [7:0]      out_data;
  logic            out_last;
  logic            out_ready;
  logic [1:0]      grant_sel;
  logic            busy;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  rr_arbiter #(.data_bits(8), .sel_bits(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant_sel (grant_sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Scoreboard monitor: every output transfer must match the next queued beat.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got data=%h last=%b want nothing", out_data, out_last);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({out_data, out_last} !== e) begin
          errors++;
          $display("FAIL sb_beat got data=%h last=%b want data=%h last=%b",
                   out_data, out_last, e[8:1], e[0]);
        end
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push(logic [7:0] d, logic l);
    exp_q.push_back({d, l});
  endtask

  // Returns at mid-cycle once req_ready[r] is high; the caller's next step()
  // completes the transfer.
  task automatic wait_ready(int r);
    for (int i = 0; i < 20; i++) begin
      mid();
      if (req_ready[r] === 1'b1) begin
        checks++;
        return;
      end
      step();
    end
    checks++;
    errors++;
    $display("FAIL wait_ready%0d got timeout want ready", r);
  endtask

  task automatic do_reset();
    repeat (3) step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    out_ready = 1'b1;
    step();
    step();

    // Reset state
    mid();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_sel, 0);
    check("rst_ready", req_ready, 0);
    step();
    rst = 1'b0;

    // Single requester 2, three-beat packet, full throughput
    req_valid   = 4'b0100;
    req_data[2] = 8'h11;
    req_last[2] = 1'b0;
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 1);
    mid();
    check("t1_idle_ready", req_ready, 0);
    check("t1_idle_busy", busy, 0);
    step();
    mid();
    check("t1_grant", grant_sel, 2);
    check("t1_busy", busy, 1);
    check("t1_ready", req_ready, 4'b0100);
    step();
    req_data[2] = 8'h22;
    mid();
    check("t1_latency_valid", out_valid, 1);
    step();
    req_data[2] = 8'h33;
    req_last[2] = 1'b1;
    step();
    // ptr is now 3: with 0, 1 and 3 requesting, 3 must win
    req_valid   = 4'b1011;
    req_last    = 4'b1111;
    req_data[0] = 8'h30;
    req_data[1] = 8'h31;
    req_data[3] = 8'h3f;
    push(8'h3f, 1);
    mid();
    check("t1_back_to_idle", busy, 0);
    step();
    mid();
    check("t1_ptr3_grant", grant_sel, 3);
    step();
    req_valid = '0;

    // Fairness from reset: 0,1,2,3,0 with single-beat packets
    do_reset();
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    req_data  = {8'h43, 8'h42, 8'h41, 8'h40};
    push(8'h40, 1); push(8'h41, 1); push(8'h42, 1); push(8'h43, 1); push(8'h44, 1);
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % 4;
      wait_ready(e);
      check($sformatf("fair_grant%0d", k), grant_sel, e);
      check($sformatf("fair_ready%0d", k), req_ready, 4'b0001 << e);
      step();
      if (e == 0) req_data[0] = 8'h44;
    end
    req_valid = '0;

    // Backpressure on owner 1
    do_reset();
    req_valid   = 4'b0010;
    req_data[1] = 8'ha0;
    req_last[1] = 1'b0;
    push(8'ha0, 0); push(8'ha1, 1);
    wait_ready(1);
    step();
    req_data[1] = 8'ha1;
    req_last[1] = 1'b1;
    out_ready   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check($sformatf("bp_ready%0d", i), req_ready, 0);
      check($sformatf("bp_hold_data%0d", i), out_data, 8'ha0);
      check($sformatf("bp_hold_valid%0d", i), out_valid, 1);
      step();
    end
    out_ready = 1'b1;
    mid();
    check("bp_release_ready", req_ready, 4'b0010);
    step();
    req_valid = '0;

    // Lock: requester 3 ignored while 0 owns the output
    do_reset();
    req_valid   = 4'b0001;
    req_data[0] = 8'hc0;
    req_last[0] = 1'b0;
    push(8'hc0, 0); push(8'hc1, 0); push(8'hc2, 1); push(8'hd0, 1);
    wait_ready(0);
    step();
    req_valid   = 4'b1001;
    req_data[0] = 8'hc1;
    req_data[3] = 8'hd0;
    req_last[3] = 1'b1;
    mid();
    check("lock_ready_a", req_ready, 4'b0001);
    step();
    req_data[0] = 8'hc2;
    req_last[0] = 1'b1;
    mid();
    check("lock_ready_b", req_ready, 4'b0001);
    step();
    req_valid = 4'b1000;
    mid();
    check("lock_idle_busy", busy, 0);
    check("lock_idle_ready", req_ready, 0);
    step();
    mid();
    check("lock_grant3", grant_sel, 3);
    check("lock_ready3", req_ready, 4'b1000);
    step();
    req_valid = '0;

    // Reset mid-packet from requester 2 (ptr first moved off zero)
    do_reset();
    req_valid   = 4'b0100;
    req_data[2] = 8'he0;
    req_last[2] = 1'b0;
    push(8'he0, 0); push(8'he1, 0);
    wait_ready(2);
    step();
    req_data[2] = 8'he1;
    step();
    rst         = 1'b1;
    req_data[2] = 8'he2;
    mid();
    check("rstmid_ready", req_ready, 0);
    step();
    rst       = 1'b0;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    req_data  = {8'hf3, 8'hf2, 8'hf1, 8'hf0};
    push(8'hf0, 1);
    mid();
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_busy", busy, 0);
    step();
    mid();
    check("rstmid_grant", grant_sel, 0);
    check("rstmid_ready_owner", req_ready, 4'b0001);
    step();
    req_valid = '0;

    // Gap: owner 1 goes quiet mid-packet, others must stay locked out
    req_valid   = 4'b0010;
    req_data[1] = 8'h91;
    req_last[1] = 1'b0;
    push(8'h91, 0); push(8'h92, 1); push(8'hb2, 1); push(8'hb0, 1);
    wait_ready(1);
    step();
    req_valid   = 4'b0101;
    req_data[0] = 8'hb0;
    req_data[2] = 8'hb2;
    req_last[0] = 1'b1;
    req_last[2] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mid();
      check($sformatf("gap_busy%0d", i), busy, 1);
      check($sformatf("gap_grant%0d", i), grant_sel, 1);
      check($sformatf("gap_ready%0d", i), req_ready, 4'b0010);
      step();
    end
    req_valid   = 4'b0111;
    req_data[1] = 8'h92;
    req_last[1] = 1'b1;
    mid();
    check("gap_resume_ready", req_ready, 4'b0010);
    step();
    req_valid = 4'b0101;
    wait_ready(2);
    check("gap_next_grant2", grant_sel, 2);
    step();
    req_valid = 4'b0001;
    wait_ready(0);
    check("gap_next_grant0", grant_sel, 0);
    step();
    req_valid = '0;

    repeat (4) step();
    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 SHALL have parameter data_bits, default 8, width of each requester data bus.
REQ-002 SHALL have parameter sel_bits, default 2; N = 2**sel_bits requesters.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  N  per-requester beat valid.
REQ-006 SHALL have port req_data  input  [N][data_bits]  packed per-requester data; index i = requester i.
REQ-007 SHALL have port req_last  input  N  per-requester end-of-packet flag.
REQ-008 SHALL have port req_ready  output  N  per-requester accept; beat transfers when req_valid[i] & req_ready[i].
REQ-009 SHALL have port out_valid  output  1  registered output beat valid.
REQ-010 SHALL have port out_data  output  data_bits  registered output data.
REQ-011 SHALL have port out_last  output  1  registered end-of-packet flag.
REQ-012 SHALL have port out_ready  input  1  downstream accept; output transfer when out_valid & out_ready.
REQ-013 SHALL have port grant_sel  output  sel_bits  index of current owner; drives the shared data mux select.
REQ-014 SHALL have port busy  output  1  high while FSM is in LOCKED.

Function
REQ-015 SHALL implement FSM with states IDLE and LOCKED, plus round-robin pointer ptr (sel_bits wide).
REQ-016 In IDLE, if any req_valid set, SHALL select first i with req_valid[i]=1 scanning ptr, ptr+1, ... modulo N; load grant_sel=i; go to LOCKED next cycle.
REQ-017 In IDLE, req_ready SHALL be all-zero; no beat is accepted in the arbitration cycle.
REQ-018 In IDLE with no req_valid, SHALL stay in IDLE; grant_sel holds its last value.
REQ-019 In LOCKED, req_ready[grant_sel] SHALL equal (!out_valid | out_ready); all other req_ready bits 0.
REQ-020 On accepted beat, output register SHALL load req_data[grant_sel], req_last[grant_sel] and set out_valid=1 on the next edge.
REQ-021 Output register SHALL hold data/last/valid stable while out_valid & !out_ready.
REQ-022 On output transfer with no new accepted beat in same cycle, out_valid SHALL clear next edge.
REQ-023 Simultaneous output transfer and new input accept SHALL replace register contents with no bubble (full throughput, 1 beat/cycle).
REQ-024 On accepted beat with req_last=1, SHALL go to IDLE next cycle and set ptr = grant_sel+1 modulo N (wraps N-1 -> 0).
REQ-025 Owner deasserting req_valid mid-packet SHALL NOT release the grant; no timeout.
REQ-026 Requests from non-owners during LOCKED SHALL be ignored (not accepted, not queued).
REQ-027 Latency: req_valid asserted in IDLE at cycle t -> req_ready at t+1 -> out_valid at t+2 (if accepted at t+1).
REQ-028 Pending output beat (out_valid=1) SHALL NOT block returning to IDLE or the next arbitration; next owner accepts only once register frees per REQ-019.
REQ-029 busy SHALL be 1 exactly when state is LOCKED.

Reset
REQ-030 On rst=1 at a clock edge, SHALL set state=IDLE, ptr=0, grant_sel=0, out_valid=0, out_data=0, out_last=0, regardless of state.
REQ-031 During reset cycle, req_ready SHALL be all-zero; a beat in flight mid-packet SHALL be discarded; no partial recovery.

Verification (sel_bits=2, data_bits=8)
REQ-032 Single requester: req_valid=4'b0100, 3-beat packet 0x11,0x22,0x33(last), out_ready=1 -> grant_sel=2, out_data 0x11,0x22,0x33 on consecutive cycles from t+2, out_last with 0x33, ptr=3.
REQ-033 Fairness: all four valid continuously, 1-beat packets -> grant order 0,1,2,3,0 after reset; wrap from 3 to 0 verified.
REQ-034 Backpressure: owner 1 sends 0xA0,0xA1(last), out_ready=0 for 3 cycles after first beat -> out_data holds 0xA0, req_ready[1]=0 while stalled, no beat lost or duplicated.
REQ-035 Lock: owner 0 mid-packet, req_valid[3] rises -> req_ready[3]=0 until owner 0 last accepted; then grant_sel=3 after one IDLE cycle.
REQ-036 Reset mid-packet: rst=1 after 2nd of 4 beats from requester 2 -> next cycle out_valid=0, busy=0, ptr=0; with all valid, next grant_sel=0.
REQ-037 Gap: owner drops req_valid for 2 cycles mid-packet -> busy stays 1, grant_sel unchanged, no other requester accepted.
